// File: rtl/inert_intf_ctrl.sv
// inert_intf_ctrl
//   Sequences the SPI master for the inertial sensor. After a power-up wait it
//   writes four configuration registers. It then answers each data-ready
//   interrupt by reading pitch rate and Z acceleration one byte at a time,
//   and strobes vld when a complete sample is ready for the integrator.
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   INT        : sensor data-ready level (asynchronous, synchronized here)
//   done       : SPI transaction complete pulse
//   rd_data    : SPI read word, only [7:0] carries the register byte
//   wrt, cmd   : SPI start pulse and command word (cmd holds between issues)
//   ptch_rt    : {PH, PL} signed pitch rate
//   AZ         : {AH, AL} signed Z acceleration
//   vld        : one-cycle strobe, sample is complete in that cycle
module inert_intf_ctrl #(
    parameter int INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    typedef enum logic [3:0] {
        INIT_WAIT, CFG0, CFG1, CFG2, CFG3,
        IDLE, RD_PL, RD_PH, RD_AL, RD_AH
    } state_t;

    state_t              state, nxt_state;
    logic                int_ff1, int_s;
    logic [INIT_W-1:0]   cnt;
    logic [7:0]          pl, ph, al, ah;
    logic                xfer_done;
    logic                issue;
    logic [15:0]         issue_cmd;
    logic                cap_pl, cap_ph, cap_al, cap_ah;
    logic                set_vld;
    logic                unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    // A done pulse coincident with wrt belongs to no transaction yet: the
    // master has not even seen the start request.
    assign xfer_done = done & ~wrt;

    assign ptch_rt = {ph, pl};
    assign AZ      = {ah, al};

    // Two-flop synchronizer for the asynchronous interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_s   <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_s   <= int_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT_WAIT;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        issue     = 1'b0;
        issue_cmd = 16'h0000;
        cap_pl    = 1'b0;
        cap_ph    = 1'b0;
        cap_al    = 1'b0;
        cap_ah    = 1'b0;
        set_vld   = 1'b0;
        case (state)
            INIT_WAIT: if (&cnt) begin
                nxt_state = CFG0; issue = 1'b1; issue_cmd = 16'h0D02;
            end
            CFG0: if (xfer_done) begin
                nxt_state = CFG1; issue = 1'b1; issue_cmd = 16'h1053;
            end
            CFG1: if (xfer_done) begin
                nxt_state = CFG2; issue = 1'b1; issue_cmd = 16'h1150;
            end
            CFG2: if (xfer_done) begin
                nxt_state = CFG3; issue = 1'b1; issue_cmd = 16'h1460;
            end
            CFG3: if (xfer_done) nxt_state = IDLE;
            // Level sensitive: a stuck INT restarts a read right after RD_AH
            IDLE: if (int_s) begin
                nxt_state = RD_PL; issue = 1'b1; issue_cmd = 16'hA200;
            end
            RD_PL: if (xfer_done) begin
                cap_pl = 1'b1; nxt_state = RD_PH; issue = 1'b1; issue_cmd = 16'hA300;
            end
            RD_PH: if (xfer_done) begin
                cap_ph = 1'b1; nxt_state = RD_AL; issue = 1'b1; issue_cmd = 16'hAC00;
            end
            RD_AL: if (xfer_done) begin
                cap_al = 1'b1; nxt_state = RD_AH; issue = 1'b1; issue_cmd = 16'hAD00;
            end
            RD_AH: if (xfer_done) begin
                cap_ah = 1'b1; set_vld = 1'b1; nxt_state = IDLE;
            end
            default: nxt_state = INIT_WAIT;
        endcase
    end

    // Power-up counter only runs while waiting; it wraps to 0 on leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (state == INIT_WAIT) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt <= 1'b0;
            cmd <= 16'h0000;
            vld <= 1'b0;
        end else begin
            wrt <= issue;
            vld <= set_vld;
            if (issue) cmd <= issue_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl <= 8'h00;
            ph <= 8'h00;
            al <= 8'h00;
            ah <= 8'h00;
        end else begin
            if (cap_pl) pl <= rd_data[7:0];
            if (cap_ph) ph <= rd_data[7:0];
            if (cap_al) al <= rd_data[7:0];
            if (cap_ah) ah <= rd_data[7:0];
        end
    end

endmodule

// File: tb/tb_inert_intf_ctrl.sv
module tb_inert_intf_ctrl;

    localparam int INIT_W = 4;

    logic        clk, rst_n, INT, done, wrt, vld;
    logic [15:0] rd_data, cmd, ptch_rt, AZ;
    logic        mdone, spur_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_wrt = 0;
    int n_vld = 0;

    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_byte[$];
    logic [31:0] exp_smp[$];

    logic        busy = 1'b0;
    int          mcnt = 0;
    logic        vld_prev = 1'b0;

    assign done = mdone | spur_done;

    inert_intf_ctrl #(.INIT_W(INIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SPI master model: checks command order and the one-outstanding rule,
    // answers each wrt with done 8 clocks later.
    always @(negedge clk) begin
        logic [15:0] ec;
        logic [7:0]  b;
        if (!rst_n) begin
            busy = 1'b0; mdone = 1'b0; mcnt = 0; rd_data = 16'hFFEE;
        end else begin
            mdone   = 1'b0;
            rd_data = 16'hFFEE;
            if (wrt) begin
                n_wrt++;
                chk("overlap", {31'd0, busy}, 32'd0);
                ec = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 16'hxxxx;
                chk("cmd", {16'd0, cmd}, {16'd0, ec});
                b  = 8'h00;
                if (cmd[15]) b = (exp_byte.size() > 0) ? exp_byte.pop_front() : 8'hxx;
                busy = 1'b1;
                mcnt = 8;
            end else if (busy) begin
                mcnt--;
                if (mcnt == 0) begin
                    mdone   = 1'b1;
                    rd_data = {8'hFF, b};
                    busy    = 1'b0;
                end
            end
        end
    end

    // Sample monitor
    always @(negedge clk) begin
        logic [31:0] s;
        if (rst_n) begin
            if (vld) begin
                n_vld++;
                chk("vld_width", {31'd0, vld_prev}, 32'd0);
                s = (exp_smp.size() > 0) ? exp_smp.pop_front() : 32'hxxxxxxxx;
                chk("ptch_rt", {16'd0, ptch_rt}, {16'd0, s[31:16]});
                chk("AZ", {16'd0, AZ}, {16'd0, s[15:0]});
            end
            vld_prev = vld;
        end else begin
            vld_prev = 1'b0;
        end
    end

    task automatic push_cfg();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1053);
        exp_cmd.push_back(16'h1150);
        exp_cmd.push_back(16'h1460);
    endtask

    task automatic push_read(input logic [7:0] pl, ph, al, ah);
        exp_cmd.push_back(16'hA200);
        exp_cmd.push_back(16'hA300);
        exp_cmd.push_back(16'hAC00);
        exp_cmd.push_back(16'hAD00);
        exp_byte.push_back(pl);
        exp_byte.push_back(ph);
        exp_byte.push_back(al);
        exp_byte.push_back(ah);
        exp_smp.push_back({ph, pl, ah, al});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_cmd.size() == 0 && exp_smp.size() == 0 && !busy) break;
        end
        chk({tag, "_cmds_left"}, exp_cmd.size(), 0);
        chk({tag, "_smps_left"}, exp_smp.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Release reset at a negedge and count edges until wrt is first seen.
    task automatic release_and_time(input string tag);
        int k;
        rst_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wrt) begin k = i; break; end
        end
        chk(tag, k, 1 << INIT_W);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrt"}, {31'd0, wrt}, 32'd0);
        chk({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
        chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
        chk({tag, "_ptch"}, {16'd0, ptch_rt}, 32'd0);
        chk({tag, "_az"}, {16'd0, AZ}, 32'd0);
    endtask

    initial begin
        int base;
        INT = 1'b0; spur_done = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");

        // Power-up: wait, then the config writes
        push_cfg();
        release_and_time("first_wrt");
        wait_idle("cfg");
        repeat (40) @(negedge clk);
        chk("no_wrt_idle", n_wrt, 4);

        // Single sample
        push_read(8'h34, 8'h12, 8'hCD, 8'hAB);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_idle("single");
        chk("single_vld_cnt", n_vld, 1);
        chk("single_ptch", {16'd0, ptch_rt}, 32'h1234);
        chk("single_az", {16'd0, AZ}, 32'hABCD);

        // Stuck INT: three back-to-back sequences
        for (int k = 0; k < 3; k++)
            push_read(8'h80 + 8'(k), 8'h10 + 8'(k), 8'h40 + 8'(k), 8'hF0 + 8'(k));
        INT = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (n_vld >= 3) break;
        end
        chk("stuck_wait", n_vld, 3);
        INT = 1'b0;
        wait_idle("stuck");
        chk("stuck_vld_cnt", n_vld, 4);
        chk("stuck_wrt_cnt", n_wrt, 20);

        // Spurious done while idle
        base = n_wrt;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("spur_idle_wrt", n_wrt, base);
        chk("spur_idle_vld", n_vld, 4);
        chk("spur_idle_ptch", {16'd0, ptch_rt}, 32'h1282);
        chk("spur_idle_az", {16'd0, AZ}, 32'hF242);

        // Spurious done coincident with wrt
        push_read(8'h11, 8'h22, 8'h33, 8'h44);
        INT = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wrt) break;
        end
        chk("spur_wrt_seen", {31'd0, wrt}, 32'd1);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        INT = 1'b0;
        wait_idle("spur_wrt");
        chk("spur_wrt_vld_cnt", n_vld, 5);
        chk("spur_wrt_ptch", {16'd0, ptch_rt}, 32'h2211);
        chk("spur_wrt_az", {16'd0, AZ}, 32'h4433);

        // Reset during RD_AL
        push_read(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        INT = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wrt && cmd == 16'hAC00) break;
        end
        chk("rd_al_seen", {16'd0, cmd}, 32'hAC00);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_cmd.delete();
        exp_byte.delete();
        exp_smp.delete();
        @(negedge clk);
        chk_zero("midrd_reset");
        repeat (2) @(negedge clk);
        base = n_wrt;
        push_cfg();
        release_and_time("rerun_first_wrt");
        wait_idle("recfg");
        repeat (40) @(negedge clk);
        chk("recfg_wrt_cnt", n_wrt - base, 4);
        chk("recfg_vld_cnt", n_vld, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
